line_oblique: RTL and testbench

- Oblique line renderer for the 800x480 MTL LCD pipeline.
- Owns the raster scan counters.
- Rasterises a straight segment from (x_offset,y_offset) to (x_final,y_final) using Bresenham, and drives RGB with a white line on a black background.
- Bresenham engine runs one scan row ahead of display and produces a per-row x-span; the display compares that span against the scan position.

---
 rtl/line_oblique_pkg.sv | 30 +++
 rtl/line_oblique_bresenham.sv | 143 ++++++++++++++
 rtl/line_oblique.sv | 92 +++++++++
 tb/tb_line_oblique.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/line_oblique_pkg.sv
// Shared timing, colour, engine-state and span types for the oblique line renderer.
package line_oblique_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned H_TOTAL  = 1056;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_TOTAL  = 525;

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned CW = 8;
  localparam int unsigned EW = 13;

  localparam logic [CW-1:0] COL_LINE = 8'hFF;
  localparam logic [CW-1:0] COL_BG   = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } eng_state_e;

  typedef struct packed {
    logic          valid;
    logic [XW-1:0] lo;
    logic [XW-1:0] hi;
  } span_t;

endpackage

// File: rtl/line_oblique_bresenham.sv
// Bresenham engine: walks the segment one point per clock, one row ahead of display,
// and hands a per-row x-span to the display on each end-of-row pulse.
module line_oblique_bresenham
  import line_oblique_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [XW-1:0] i_x0,
  input  logic [YW-1:0] i_y0,
  input  logic [XW-1:0] i_x1,
  input  logic [YW-1:0] i_y1,
  input  logic          i_row_end,
  input  logic [YW-1:0] i_row,
  output logic [XW-1:0] o_xline,
  output logic [YW-1:0] o_yline,
  output span_t         o_span,
  output logic          o_done
);

  eng_state_e           r_state, w_state_nxt;
  logic [XW-1:0]        r_xline, w_xline_nxt, r_xend;
  logic [YW-1:0]        r_yline, w_yline_nxt, r_yend;
  logic signed [EW-1:0] r_err, w_err_nxt, r_dx, r_dy;
  logic                 r_sx_neg;
  logic                 r_done, w_done_nxt;
  span_t                r_work, w_work_nxt, r_disp, w_disp_nxt;

  // Endpoint normalisation so the walk always moves downward in y
  logic          w_swap;
  logic [XW-1:0] w_lx0, w_lx1, w_ldx;
  logic [YW-1:0] w_ly0, w_ly1, w_ldy;
  assign w_swap = i_y1 < i_y0;
  assign w_lx0  = w_swap ? i_x1 : i_x0;
  assign w_ly0  = w_swap ? i_y1 : i_y0;
  assign w_lx1  = w_swap ? i_x0 : i_x1;
  assign w_ly1  = w_swap ? i_y0 : i_y1;
  assign w_ldx  = (w_lx1 >= w_lx0) ? (w_lx1 - w_lx0) : (w_lx0 - w_lx1);
  assign w_ldy  = w_ly1 - w_ly0;

  logic signed [EW:0] w_e2, w_dx_e, w_dy_e;
  logic               w_cx, w_cy, w_on_row, w_at_end;
  logic [XW-1:0]      w_xadv;
  logic [YW-1:0]      w_yadv;
  assign w_e2     = {r_err, 1'b0};
  assign w_dx_e   = {r_dx[EW-1], r_dx};
  assign w_dy_e   = {r_dy[EW-1], r_dy};
  assign w_cx     = w_e2 > -w_dy_e;
  assign w_cy     = w_e2 < w_dx_e;
  assign w_xadv   = !w_cx ? r_xline : (r_sx_neg ? r_xline - XW'(1) : r_xline + XW'(1));
  assign w_yadv   = w_cy ? r_yline + YW'(1) : r_yline;
  assign w_on_row = r_yline == i_row;
  assign w_at_end = (r_xline == r_xend) && (r_yline == r_yend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_xline  <= '0;
      r_yline  <= '0;
      r_err    <= '0;
      r_work   <= '0;
      r_disp   <= '0;
      r_done   <= 1'b0;
      r_xend   <= '0;
      r_yend   <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_xline <= w_xline_nxt;
      r_yline <= w_yline_nxt;
      r_err   <= w_err_nxt;
      r_work  <= w_work_nxt;
      r_disp  <= w_disp_nxt;
      r_done  <= w_done_nxt;
      if (i_load) begin
        r_xend   <= w_lx1;
        r_yend   <= w_ly1;
        r_dx     <= EW'(w_ldx);
        r_dy     <= EW'(w_ldy);
        r_sx_neg <= w_lx1 < w_lx0;
      end
    end
  end

  // Rows above the start point are skipped without stepping so no point is lost
  always_comb begin
    w_state_nxt = r_state;
    w_xline_nxt = r_xline;
    w_yline_nxt = r_yline;
    w_err_nxt   = r_err;
    w_work_nxt  = r_work;
    w_disp_nxt  = r_disp;
    w_done_nxt  = r_done;
    if (i_load) begin
      w_state_nxt = ST_STEP;
      w_xline_nxt = w_lx0;
      w_yline_nxt = w_ly0;
      w_err_nxt   = EW'(w_ldx) - EW'(w_ldy);
      w_work_nxt  = '0;
      w_disp_nxt  = '0;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_STEP: begin
          if (r_yline > i_row) begin
            w_state_nxt = ST_WAIT;
          end else begin
            if (w_on_row) begin
              w_work_nxt.valid = 1'b1;
              w_work_nxt.lo = (!r_work.valid || r_xline < r_work.lo) ? r_xline : r_work.lo;
              w_work_nxt.hi = (!r_work.valid || r_xline > r_work.hi) ? r_xline : r_work.hi;
            end
            if (w_at_end) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_xline_nxt = w_xadv;
              w_yline_nxt = w_yadv;
              w_err_nxt   = r_err - (w_cx ? r_dy : '0) + (w_cy ? r_dx : '0);
              if (w_yadv > i_row) w_state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT, ST_DONE: begin
          if (i_row_end) begin
            w_disp_nxt = r_work;
            w_work_nxt = '0;
            if (r_state == ST_WAIT) w_state_nxt = ST_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_xline = r_xline;
  assign o_yline = r_yline;
  assign o_span  = r_disp;
  assign o_done  = r_done;

endmodule

// File: rtl/line_oblique.sv
// Oblique line renderer: raster scan counters, Bresenham engine and white-on-black
// colour mux for the MTL LCD pixel stream.
module line_oblique
  import line_oblique_pkg::*;
#(
  parameter int unsigned P_H_ACTIVE = H_ACTIVE,
  parameter int unsigned P_H_TOTAL  = H_TOTAL,
  parameter int unsigned P_V_ACTIVE = V_ACTIVE,
  parameter int unsigned P_V_TOTAL  = V_TOTAL
)(
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] x_offset,
  input  logic [YW-1:0] y_offset,
  input  logic [XW-1:0] x_final,
  input  logic [YW-1:0] y_final,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue,
  output logic [XW-1:0] Xcount,
  output logic [YW-1:0] Ycount,
  output logic [XW-1:0] Xline,
  output logic [YW-1:0] Yline,
  output logic          x_period,
  output logic          y_period,
  output logic          start_mark,
  output logic          done_mark,
  output logic          curseur
);

  logic [XW-1:0] r_xcount, w_xcount_nxt;
  logic [YW-1:0] r_ycount, w_ycount_nxt;
  logic          r_xper, r_yper, r_start;
  logic [YW-1:0] r_row;
  logic          w_xwrap, w_xper_nxt;
  span_t         w_span;

  assign w_xwrap      = r_xcount == XW'(P_H_TOTAL - 1);
  assign w_xcount_nxt = w_xwrap ? '0 : r_xcount + XW'(1);
  assign w_ycount_nxt = !w_xwrap ? r_ycount :
                        (r_ycount == YW'(P_V_TOTAL - 1)) ? '0 : r_ycount + YW'(1);
  assign w_xper_nxt   = w_xcount_nxt == XW'(P_H_TOTAL - 1);

  // Pulses are pre-decoded from the next count so they align with the count they mark
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xcount <= '0;
      r_ycount <= '0;
      r_xper   <= 1'b0;
      r_yper   <= 1'b0;
      r_start  <= 1'b0;
      r_row    <= '0;
    end else begin
      r_xcount <= w_xcount_nxt;
      r_ycount <= w_ycount_nxt;
      r_xper   <= w_xper_nxt;
      r_yper   <= w_xper_nxt && (w_ycount_nxt == YW'(P_V_TOTAL - 1));
      r_start  <= w_xper_nxt && (w_ycount_nxt == YW'(P_V_TOTAL - 2));
      if (r_start)     r_row <= '0;
      else if (r_xper) r_row <= r_row + YW'(1);
    end
  end

  line_oblique_bresenham u_bresenham (
    .clk       (clk),
    .rst_n     (reset),
    .i_load    (r_start),
    .i_x0      (x_offset),
    .i_y0      (y_offset),
    .i_x1      (x_final),
    .i_y1      (y_final),
    .i_row_end (r_xper),
    .i_row     (r_row),
    .o_xline   (Xline),
    .o_yline   (Yline),
    .o_span    (w_span),
    .o_done    (done_mark)
  );

  assign curseur = (r_xcount < XW'(P_H_ACTIVE)) && (r_ycount < YW'(P_V_ACTIVE)) &&
                   w_span.valid && (r_xcount >= w_span.lo) && (r_xcount <= w_span.hi);

  assign red        = curseur ? COL_LINE : COL_BG;
  assign green      = curseur ? COL_LINE : COL_BG;
  assign blue       = curseur ? COL_LINE : COL_BG;
  assign Xcount     = r_xcount;
  assign Ycount     = r_ycount;
  assign x_period   = r_xper;
  assign y_period   = r_yper;
  assign start_mark = r_start;

endmodule

// File: tb/tb_line_oblique.sv
// Scoreboard bench for line_oblique on a reduced raster: a reference Bresenham model
// queues expected lit pixels per line; a monitor pops them as the DUT lights pixels.
module tb_line_oblique;

  localparam int HA = 100;
  localparam int HT = 120;
  localparam int VA = 34;
  localparam int VT = 40;
  localparam int NL = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x_offset, x_final;
  logic [9:0]  y_offset, y_final;
  logic [7:0]  red, green, blue;
  logic [10:0] Xcount, Xline;
  logic [9:0]  Ycount, Yline;
  logic        x_period, y_period, start_mark, done_mark, curseur;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int mxc = 0;
  int myc = 0;

  line_oblique #(
    .P_H_ACTIVE(HA), .P_H_TOTAL(HT), .P_V_ACTIVE(VA), .P_V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset(reset),
    .x_offset(x_offset), .y_offset(y_offset), .x_final(x_final), .y_final(y_final),
    .red(red), .green(green), .blue(blue),
    .Xcount(Xcount), .Ycount(Ycount), .Xline(Xline), .Yline(Yline),
    .x_period(x_period), .y_period(y_period), .start_mark(start_mark),
    .done_mark(done_mark), .curseur(curseur)
  );

  always #5 clk = ~clk;

  // Reference raster position
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mxc = 0;
      myc = 0;
    end else if (mxc == HT - 1) begin
      mxc = 0;
      myc = (myc == VT - 1) ? 0 : myc + 1;
    end else begin
      mxc = mxc + 1;
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    cmp({name, "_flags"}, {red, green, blue, x_period, y_period, start_mark, done_mark, curseur}, 64'd0);
    cmp({name, "_counts"}, {Xcount, Ycount, Xline, Yline}, 64'd0);
  endtask

  // Monitor: scan timing every cycle, pixel scoreboard whenever a pixel is lit
  always @(negedge clk) begin : mon
    int e;
    int a;
    logic [23:0] exp_s;
    if (reset === 1'b1) begin
      exp_s = {11'(mxc), 10'(myc), 1'(mxc == HT - 1),
               1'((mxc == HT - 1) && (myc == VT - 1)), 1'((mxc == HT - 1) && (myc == VT - 2))};
      cmp("scan", {Xcount, Ycount, x_period, y_period, start_mark}, 64'(exp_s));
      cmp("rgb", {red, green, blue}, curseur ? 64'hFFFFFF : 64'h0);
      if (curseur) begin
        a = int'(Ycount) * 4096 + int'(Xcount);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pixel: unexpected lit pixel x=%0d y=%0d", Xcount, Ycount);
        end else begin
          e = exp_q.pop_front();
          if (e != a) begin
            bad++;
            $display("FAIL pixel: got x=%0d y=%0d expected x=%0d y=%0d",
                     Xcount, Ycount, e % 4096, e / 4096);
          end
        end
      end
    end
  end

  // Reference Bresenham: queues visible pixels of each row span in scan order
  task automatic push_line(input int ax0, input int ay0, input int ax1, input int ay1,
                           output int sx0, output int sy0, output int sx1, output int sy1);
    int x, y, dx, dy, sx, err, e2;
    int rlo[1024];
    int rhi[1024];
    bit rhas[1024];
    if (ay1 < ay0) begin
      sx0 = ax1; sy0 = ay1; sx1 = ax0; sy1 = ay0;
    end else begin
      sx0 = ax0; sy0 = ay0; sx1 = ax1; sy1 = ay1;
    end
    dx  = (sx1 >= sx0) ? sx1 - sx0 : sx0 - sx1;
    dy  = sy1 - sy0;
    sx  = (sx1 >= sx0) ? 1 : -1;
    err = dx - dy;
    x = sx0;
    y = sy0;
    for (int n = 0; n < 4096; n++) begin
      if (!rhas[y]) begin
        rhas[y] = 1'b1; rlo[y] = x; rhi[y] = x;
      end else begin
        if (x < rlo[y]) rlo[y] = x;
        if (x > rhi[y]) rhi[y] = x;
      end
      if (x == sx1 && y == sy1) break;
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx)  begin err += dx; y += 1;  end
    end
    for (int r = 0; r < VA; r++)
      if (rhas[r])
        for (int c = rlo[r]; c <= rhi[r] && c < HA; c++) exp_q.push_back(r * 4096 + c);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2 * HT * VT; n++) begin
      @(negedge clk);
      if (start_mark === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL start_mark: got none within %0d cycles expected a pulse", 2 * HT * VT);
    end
  endtask

  int lx0[NL], ly0[NL], lx1[NL], ly1[NL];
  bit lrst[NL];

  initial begin : stim
    bit ok, prev_ok;
    int nx0, ny0, ex1, ey1;
    lx0[0] = 50; ly0[0] = 0;  lx1[0] = 90;  ly1[0] = 30; lrst[0] = 0;
    lx0[1] = 90; ly0[1] = 30; lx1[1] = 50;  ly1[1] = 0;  lrst[1] = 0;
    lx0[2] = 3;  ly0[2] = 4;  lx1[2] = 12;  ly1[2] = 4;  lrst[2] = 0;
    lx0[3] = 60; ly0[3] = 25; lx1[3] = 60;  ly1[3] = 25; lrst[3] = 0;
    lx0[4] = 7;  ly0[4] = 2;  lx1[4] = 7;   ly1[4] = 20; lrst[4] = 1;
    lx0[5] = 7;  ly0[5] = 2;  lx1[5] = 7;   ly1[5] = 20; lrst[5] = 0;
    lx0[6] = 95; ly0[6] = 5;  lx1[6] = 115; ly1[6] = 36; lrst[6] = 0;
    for (int i = 7; i < NL; i++) begin
      lx0[i] = int'($urandom_range(110, 0)); ly0[i] = int'($urandom_range(37, 0));
      lx1[i] = int'($urandom_range(110, 0)); ly1[i] = int'($urandom_range(37, 0));
      lrst[i] = 0;
    end
    nx0 = 0; ny0 = 0; ex1 = 0; ey1 = 0;
    x_offset = 11'(lx0[0]); y_offset = 10'(ly0[0]);
    x_final  = 11'(lx1[0]); y_final  = 10'(ly1[0]);
    reset = 1'b1;
    #1 reset = 1'b0;
    #49;
    check_zero("reset_hold");
    @(negedge clk);
    #2 reset = 1'b1;
    prev_ok = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < NL && ok; i++) begin
      x_offset = 11'(lx0[i]); y_offset = 10'(ly0[i]);
      x_final  = 11'(lx1[i]); y_final  = 10'(ly1[i]);
      wait_start(ok);
      if (ok) begin
        if (prev_ok) begin
          cmp("line_end", {done_mark, Xline, Yline}, {1'b1, 11'(ex1), 10'(ey1)});
          cmp("pixels_left", 64'(exp_q.size()), 64'd0);
        end
        push_line(lx0[i], ly0[i], lx1[i], ly1[i], nx0, ny0, ex1, ey1);
        @(negedge clk);
        cmp("line_load", {done_mark, Xline, Yline}, {1'b0, 11'(nx0), 10'(ny0)});
        prev_ok = 1'b1;
        if (lrst[i]) begin
          for (int n = 0; n < HT * VT && Ycount != 10'd10; n++) @(negedge clk);
          cmp("mid_row", 64'(Ycount), 64'd10);
          #2 reset = 1'b0;
          #1 check_zero("mid_reset");
          exp_q.delete();
          repeat (3) @(negedge clk);
          #2 reset = 1'b1;
          prev_ok = 1'b0;
        end
      end
    end
    if (ok) begin
      wait_start(ok);
      if (ok && prev_ok) begin
        cmp("line_end", {done_mark, Xline, Yline}, {1'b1, 11'(ex1), 10'(ey1)});
        cmp("pixels_left", 64'(exp_q.size()), 64'd0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
